// File: rtl/timer_sched_ctrl.sv
// rtl/timer_sched_ctrl.sv - round-robin scheduler sharing one interval timer between one-shot delay requesters
// Each grant programs period_l/period_h, starts the timer with ITO set, waits for irq, clears status, pulses done.
module timer_sched_ctrl #(
  parameter int NUM_REQ = 4,
  parameter int DELAY_W = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*DELAY_W-1:0] req_delay,
  output logic [NUM_REQ-1:0]         grant,
  output logic [NUM_REQ-1:0]         done,
  output logic                       busy,
  output logic [2:0]                 tmr_address,
  output logic                       tmr_chipselect,
  output logic                       tmr_write_n,
  output logic [15:0]                tmr_writedata,
  input  logic                       tmr_irq
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [2:0]  ADDR_STATUS = 3'd0;
  localparam logic [2:0]  ADDR_CTRL   = 3'd1;
  localparam logic [2:0]  ADDR_PER_L  = 3'd2;
  localparam logic [2:0]  ADDR_PER_H  = 3'd3;
  localparam logic [15:0] CTRL_START  = 16'h0005;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_PL,
    S_WR_PH,
    S_WR_CTRL,
    S_WAIT_IRQ,
    S_CLR_STAT,
    S_DONE
  } state_t;

  state_t               r_state, w_next_state;
  logic [IDX_W-1:0]     r_idx, w_next_idx;
  logic [IDX_W-1:0]     r_rr, w_next_rr;
  logic [DELAY_W-1:0]   r_delay, w_next_delay;

  logic [NUM_REQ-1:0]   r_grant, r_done;
  logic                 r_busy, r_cs, r_write_n;
  logic [2:0]           r_addr;
  logic [15:0]          r_wdata;

  logic                 w_any;
  logic [IDX_W-1:0]     w_sel_idx;
  logic [DELAY_W-1:0]   w_sel_delay;
  logic [NUM_REQ-1:0]   w_next_onehot;
  logic [NUM_REQ-1:0]   w_grant, w_done;
  logic                 w_busy, w_cs, w_write_n;
  logic [2:0]           w_addr;
  logic [15:0]          w_wdata;

  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDX_W'(s);
  endfunction

  // First requester at or after the pointer wins; the pointer moves past each served index.
  always_comb begin
    w_any     = 1'b0;
    w_sel_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_any && req[wrap_add(r_rr, k)]) begin
        w_any     = 1'b1;
        w_sel_idx = wrap_add(r_rr, k);
      end
    end
    w_sel_delay = req_delay[DELAY_W*int'(w_sel_idx) +: DELAY_W];
  end

  always_comb begin
    w_next_state = r_state;
    w_next_idx   = r_idx;
    w_next_delay = r_delay;
    w_next_rr    = r_rr;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_next_idx   = w_sel_idx;
          w_next_delay = w_sel_delay;
          w_next_state = (w_sel_delay == '0) ? S_DONE : S_WR_PL;
        end
      end
      S_WR_PL:    w_next_state = S_WR_PH;
      // Start must land right after the period-high write so it overrides the timer's reload-stop.
      S_WR_PH:    w_next_state = S_WR_CTRL;
      S_WR_CTRL:  w_next_state = S_WAIT_IRQ;
      S_WAIT_IRQ: if (tmr_irq) w_next_state = S_CLR_STAT;
      S_CLR_STAT: w_next_state = S_DONE;
      S_DONE: begin
        w_next_state = S_IDLE;
        w_next_rr    = (r_idx == IDX_W'(NUM_REQ - 1)) ? '0 : r_idx + 1'b1;
      end
      default:    w_next_state = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered values line up with the state they belong to.
  always_comb begin
    w_next_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_next_idx;
    w_grant       = '0;
    w_done        = '0;
    w_busy        = (w_next_state != S_IDLE);
    w_cs          = 1'b0;
    w_write_n     = 1'b1;
    w_addr        = ADDR_STATUS;
    w_wdata       = '0;
    if (w_next_state != S_IDLE) w_grant = w_next_onehot;
    case (w_next_state)
      S_WR_PL: begin
        w_cs      = 1'b1;
        w_write_n = 1'b0;
        w_addr    = ADDR_PER_L;
        w_wdata   = w_next_delay[15:0];
      end
      S_WR_PH: begin
        w_cs      = 1'b1;
        w_write_n = 1'b0;
        w_addr    = ADDR_PER_H;
        w_wdata   = w_next_delay[DELAY_W-1:16];
      end
      S_WR_CTRL: begin
        w_cs      = 1'b1;
        w_write_n = 1'b0;
        w_addr    = ADDR_CTRL;
        w_wdata   = CTRL_START;
      end
      S_CLR_STAT: begin
        w_cs      = 1'b1;
        w_write_n = 1'b0;
        w_addr    = ADDR_STATUS;
        w_wdata   = '0;
      end
      S_DONE:  w_done = w_next_onehot;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_rr      <= '0;
      r_delay   <= '0;
      r_grant   <= '0;
      r_done    <= '0;
      r_busy    <= 1'b0;
      r_cs      <= 1'b0;
      r_write_n <= 1'b1;
      r_addr    <= '0;
      r_wdata   <= '0;
    end else begin
      r_state   <= w_next_state;
      r_idx     <= w_next_idx;
      r_rr      <= w_next_rr;
      r_delay   <= w_next_delay;
      r_grant   <= w_grant;
      r_done    <= w_done;
      r_busy    <= w_busy;
      r_cs      <= w_cs;
      r_write_n <= w_write_n;
      r_addr    <= w_addr;
      r_wdata   <= w_wdata;
    end
  end

  assign grant          = r_grant;
  assign done           = r_done;
  assign busy           = r_busy;
  assign tmr_chipselect = r_cs;
  assign tmr_write_n    = r_write_n;
  assign tmr_address    = r_addr;
  assign tmr_writedata  = r_wdata;

endmodule
